// File: rtl/tetris_pkg.sv
// tetris_pkg -- shared constants and types for the Tetris input controller.
//   * Default timing constants for a 50 MHz CLOCK_50.
//   * Level range (LEVEL_MAX, LEVEL_W) and the score-to-level helper.
//   * Event priority order: a lower index wins arbitration.
//   * Repeat-FSM state type, used only when TETRIS_AUTOREPEAT_EN is defined.
package tetris_pkg;

    localparam int DEB_CYCLES_DEF   = 1000000;   // 20 ms
    localparam int GRAV_BASE_DEF    = 50000000;  // 1 s at level 0
    localparam int GRAV_STEP_DEF    = 5000000;   // 100 ms faster per level
    localparam int REPEAT_DELAY_DEF = 15000000;  // 300 ms before auto-repeat
    localparam int REPEAT_RATE_DEF  = 5000000;   // 100 ms between repeats

    localparam int LEVEL_MAX = 7;
    localparam int LEVEL_W   = 3;
    localparam int SCORE_W   = 5;

    // Event sources, listed in priority order (index 0 wins).
    localparam int PRI_LEFT  = 0;
    localparam int PRI_RIGHT = 1;
    localparam int PRI_ROT   = 2;
    localparam int PRI_GRAV  = 3;
    localparam int NUM_EVT   = 4;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    // One level per four locked pieces, saturating at LEVEL_MAX.
    function automatic logic [LEVEL_W-1:0] level_of(input logic [SCORE_W-1:0] s);
        logic [SCORE_W-1:0] q;
        q = s >> 2;
        if (q > SCORE_W'(LEVEL_MAX))
            return LEVEL_W'(LEVEL_MAX);
        return q[LEVEL_W-1:0];
    endfunction

endpackage

// File: rtl/tetris_input_ctrl_btn_debounce.sv
// btn_debounce -- one push-button cleaner.
//   Raw active-low key -> 2-flop synchronizer -> stability counter.
//   The accepted (stable) state flips only after the synchronized input has
//   disagreed with it for DEB_CYCLES consecutive cycles.
// Ports:
//   CLOCK_50   in   system clock
//   resetn     in   synchronous active-low reset
//   key_n      in   raw asynchronous button, low = pressed
//   pressed    out  debounced level, 1 = pressed (released after reset)
//   press_evt  out  one-cycle pulse on each released->pressed flip
module btn_debounce
    import tetris_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic CLOCK_50,
    input  logic resetn,
    input  logic key_n,
    output logic pressed,
    output logic press_evt
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [1:0]    sync_n;   // resets to the released level (high)
    logic          key_s;
    logic [CW-1:0] cnt;

    assign key_s = ~sync_n[1];

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            sync_n    <= 2'b11;
            pressed   <= 1'b0;
            cnt       <= '0;
            press_evt <= 1'b0;
        end else begin
            sync_n    <= {sync_n[0], key_n};
            press_evt <= 1'b0;
            if (key_s == pressed) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                // Only the released->pressed direction produces an event.
                pressed   <= key_s;
                press_evt <= key_s;
                cnt       <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tetris_input_ctrl.sv
// tetris_input_ctrl -- turns raw buttons, the pause switch and the score into
// single-cycle move/gravity requests for the game logic.
//   * Three btn_debounce instances (left, right, rotate).
//   * Gravity timer whose period shrinks with the level.
//   * Fixed-priority arbiter (left > right > rot > gravity) with a pending
//     bit per source so a losing event is issued later rather than lost.
//   * Optional left/right auto-repeat, enabled by defining the macro
//     TETRIS_AUTOREPEAT_EN; the default build has no repeat logic.
// Ports:
//   CLOCK_50, resetn (sync, active-low)
//   key_left_n, key_right_n, key_rot_n  raw buttons, low = pressed
//   pause                               raw switch, 1 = paused
//   score [4:0]                         locked-piece count
//   left_final, right_final, rot_final  one-cycle move requests
//   tick_gravity                        one-cycle gravity request
//   level [2:0]                         current speed level
// GRAV_BASE must exceed LEVEL_MAX * GRAV_STEP so every period is positive.
module tetris_input_ctrl
    import tetris_pkg::*;
#(
    parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int GRAV_BASE    = GRAV_BASE_DEF,
    parameter int GRAV_STEP    = GRAV_STEP_DEF,
    parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
    parameter int REPEAT_RATE  = REPEAT_RATE_DEF
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    input  logic               key_left_n,
    input  logic               key_right_n,
    input  logic               key_rot_n,
    input  logic               pause,
    input  logic [SCORE_W-1:0] score,
    output logic               left_final,
    output logic               right_final,
    output logic               rot_final,
    output logic               tick_gravity,
    output logic [LEVEL_W-1:0] level
);

    localparam int GW = $clog2(GRAV_BASE);

    logic [1:0]         pause_sync;
    logic               pause_s;
    logic [2:0]         key_held;
    logic [2:0]         key_press;
    logic [GW-1:0]      grav_cnt;
    logic [GW-1:0]      period_m1;
    logic               grav_evt;
    logic [NUM_EVT-1:0] evt, req, win, pend, out_q;
    logic               unused_held;

    assign pause_s = pause_sync[1];

    // ---------------------------------------------------------------- keys
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .key_n     (key_left_n),
        .pressed   (key_held[PRI_LEFT]),
        .press_evt (key_press[PRI_LEFT])
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .key_n     (key_right_n),
        .pressed   (key_held[PRI_RIGHT]),
        .press_evt (key_press[PRI_RIGHT])
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_rot (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .key_n     (key_rot_n),
        .pressed   (key_held[PRI_ROT]),
        .press_evt (key_press[PRI_ROT])
    );

    // ---------------------------------------------------------- auto-repeat
`ifdef TETRIS_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    rpt_state_e    rpt_state [2];
    logic [RW-1:0] rpt_cnt   [2];
    logic [1:0]    rep_evt;

    // Channel 0 = left, 1 = right. The press cycle itself counts as the
    // first held cycle, so DELAY starts at 1 and the first repeat lands
    // REPEAT_DELAY cycles after the press event (REPEAT_DELAY >= 2).
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            for (int i = 0; i < 2; i++) begin
                rpt_state[i] <= RPT_IDLE;
                rpt_cnt[i]   <= '0;
                rep_evt[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                rep_evt[i] <= 1'b0;
                case (rpt_state[i])
                    RPT_IDLE: begin
                        if (key_press[i]) begin
                            rpt_state[i] <= RPT_DELAY;
                            rpt_cnt[i]   <= RW'(1);
                        end
                    end
                    RPT_DELAY: begin
                        if (!key_held[i]) begin
                            rpt_state[i] <= RPT_IDLE;
                        end else if (rpt_cnt[i] == RW'(REPEAT_DELAY - 1)) begin
                            rpt_state[i] <= RPT_REPEAT;
                            rpt_cnt[i]   <= '0;
                            rep_evt[i]   <= 1'b1;
                        end else begin
                            rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
                        end
                    end
                    RPT_REPEAT: begin
                        if (!key_held[i]) begin
                            rpt_state[i] <= RPT_IDLE;
                        end else if (rpt_cnt[i] == RW'(REPEAT_RATE - 1)) begin
                            rpt_cnt[i] <= '0;
                            rep_evt[i] <= 1'b1;
                        end else begin
                            rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
                        end
                    end
                    default: rpt_state[i] <= RPT_IDLE;
                endcase
            end
        end
    end

    // Rotation never repeats, so its held level has no reader.
    assign unused_held = key_held[PRI_ROT];
`else
    // Without auto-repeat the held levels have no reader.
    assign unused_held = ^key_held;
`endif

    // ------------------------------------------------------------- gravity
    assign period_m1 = GW'(GRAV_BASE - 1 - GRAV_STEP * int'(level));
    // ">=" rather than "==" so a level-up that shortens the period below the
    // current count fires straight away instead of wrapping the counter.
    assign grav_evt  = !pause_s && (grav_cnt >= period_m1);

    // ----------------------------------------------------------- arbiter
    always_comb begin
        evt            = '0;
`ifdef TETRIS_AUTOREPEAT_EN
        evt[PRI_LEFT]  = key_press[PRI_LEFT]  | rep_evt[0];
        evt[PRI_RIGHT] = key_press[PRI_RIGHT] | rep_evt[1];
`else
        evt[PRI_LEFT]  = key_press[PRI_LEFT];
        evt[PRI_RIGHT] = key_press[PRI_RIGHT];
`endif
        evt[PRI_ROT]   = key_press[PRI_ROT];
        evt[PRI_GRAV]  = grav_evt;

        // Pause drops both fresh events and anything already waiting.
        req = pause_s ? '0 : (evt | pend);

        win = '0;
        for (int i = 0; i < NUM_EVT; i++)
            if (req[i] && (win == '0))
                win[i] = 1'b1;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            pause_sync <= 2'b00;
            level      <= '0;
            grav_cnt   <= '0;
            pend       <= '0;
            out_q      <= '0;
        end else begin
            pause_sync <= {pause_sync[0], pause};
            level      <= level_of(score);
            if (!pause_s)
                grav_cnt <= grav_evt ? '0 : grav_cnt + 1'b1;
            // A repeat of an already pending source simply merges into it.
            pend  <= req & ~win;
            out_q <= win;
        end
    end

    assign left_final   = out_q[PRI_LEFT];
    assign right_final  = out_q[PRI_RIGHT];
    assign rot_final    = out_q[PRI_ROT];
    assign tick_gravity = out_q[PRI_GRAV];

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Bench for tetris_input_ctrl with small timing parameters. A cycle-level
// reference model built from the behavioural rules (input delay line,
// run-length debounce, elapsed-time gravity, priority pick over a pending
// set) is checked every cycle, alongside directed scenario checks.
module tb_tetris_input_ctrl;

    localparam int DEB = 4;
    localparam int GB  = 40;
    localparam int GS  = 4;
    localparam int RD  = 20;
    localparam int RR  = 8;
`ifdef TETRIS_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    logic       CLOCK_50 = 1'b0;
    logic       resetn = 1'b0;
    logic       key_left_n = 1'b1, key_right_n = 1'b1, key_rot_n = 1'b1;
    logic       pause = 1'b0;
    logic [4:0] score = 5'd0;
    logic       left_final, right_final, rot_final, tick_gravity;
    logic [2:0] level;

    tetris_input_ctrl #(
        .DEB_CYCLES(DEB), .GRAV_BASE(GB), .GRAV_STEP(GS),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn),
        .key_left_n(key_left_n), .key_right_n(key_right_n), .key_rot_n(key_rot_n),
        .pause(pause), .score(score),
        .left_final(left_final), .right_final(right_final), .rot_final(rot_final),
        .tick_gravity(tick_gravity), .level(level)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int left_q[$], right_q[$], rot_q[$], grav_q[$];

    // reference model state
    logic [3:0] dq[$];          // {pause, rot_n, right_n, left_n}, 2 cycles deep
    int acc[3], run[3], pevt[3], rep[3], held_t[3];
    int pend_m[4], out_m[4];
    int lvl_m, elapsed;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic mdl_edge();
        logic [3:0] s;
        int ev[4], nevt[3], nrep[3];
        int g, pm1, won, r, want, sc;
        if (!resetn) begin
            for (int k = 0; k < 3; k++) begin
                acc[k] = 0; run[k] = 0; pevt[k] = 0; rep[k] = 0; held_t[k] = 0;
            end
            for (int i = 0; i < 4; i++) begin pend_m[i] = 0; out_m[i] = 0; end
            lvl_m = 0; elapsed = 0;
            dq.delete(); dq.push_back(4'b0111); dq.push_back(4'b0111);
            return;
        end
        s = dq.pop_front();
        dq.push_back({pause, key_rot_n, key_right_n, key_left_n});
        // gravity: a tick once P-1 unpaused cycles have elapsed
        pm1 = GB - lvl_m * GS - 1;
        g = (!s[3] && elapsed >= pm1) ? 1 : 0;
        if (!s[3]) elapsed = g ? 0 : elapsed + 1;
        ev[0] = pevt[0] | rep[0];
        ev[1] = pevt[1] | rep[1];
        ev[2] = pevt[2];
        ev[3] = g;
        won = 0;
        for (int i = 0; i < 4; i++) begin
            r = s[3] ? 0 : (pend_m[i] | ev[i]);
            out_m[i] = 0;
            if (r != 0 && won == 0) begin out_m[i] = 1; won = 1; pend_m[i] = 0; end
            else pend_m[i] = r;
        end
        sc = score;
        lvl_m = ((sc >> 2) > 7) ? 7 : (sc >> 2);
        // auto-repeat: extra events at RD, RD+RR, ... cycles of holding
        for (int k = 0; k < 3; k++) begin
            nrep[k] = 0;
            if (AUTOREP && k < 2 && acc[k] != 0) begin
                held_t[k]++;
                if (held_t[k] == RD || (held_t[k] > RD && (held_t[k] - RD) % RR == 0))
                    nrep[k] = 1;
            end
        end
        // debounce: accept after DEB consecutive disagreeing samples
        for (int k = 0; k < 3; k++) begin
            nevt[k] = 0;
            want = s[k] ? 0 : 1;
            if (want == acc[k]) run[k] = 0;
            else if (run[k] == DEB - 1) begin
                acc[k] = want; run[k] = 0; nevt[k] = want;
                if (want != 0) held_t[k] = 0;
            end else run[k]++;
        end
        for (int k = 0; k < 3; k++) begin pevt[k] = nevt[k]; rep[k] = nrep[k]; end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        mdl_edge();
        cyc++;
        #1;
        chk("outs", {28'd0, left_final, right_final, rot_final, tick_gravity},
            out_m[0] * 8 + out_m[1] * 4 + out_m[2] * 2 + out_m[3]);
        chk("level", {29'd0, level}, lvl_m);
        if (left_final === 1'b1)   left_q.push_back(cyc);
        if (right_final === 1'b1)  right_q.push_back(cyc);
        if (rot_final === 1'b1)    rot_q.push_back(cyc);
        if (tick_gravity === 1'b1) grav_q.push_back(cyc);
    endtask

    task automatic clear_q();
        left_q.delete(); right_q.delete(); rot_q.delete(); grav_q.delete();
    endtask

    task automatic meas_grav(input int exp, input string tag);
        grav_q.delete();
        for (int i = 0; i < 400 && grav_q.size() < 3; i++) step();
        chk(tag, (grav_q.size() >= 3) ? grav_q[2] - grav_q[1] : -1, exp);
    endtask

    task automatic wait_tick(output int t);
        grav_q.delete();
        for (int i = 0; i < 200 && grav_q.size() == 0; i++) step();
        chk("tick_found", grav_q.size() > 0, 1);
        t = (grav_q.size() > 0) ? grav_q[0] : cyc;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, rel;
        int rep_off[5] = '{0, 20, 28, 36, 44};

        // reset, with left held through it
        key_left_n = 1'b0;
        repeat (3) step();
        chk("reset_outs", {28'd0, left_final, right_final, rot_final, tick_gravity}, 0);
        chk("reset_level", {29'd0, level}, 0);
        clear_q();
        resetn = 1'b1;
        rel = cyc;
        repeat (12) step();
        chk("held_reset_cnt", left_q.size(), 1);
        chk("held_reset_at", (left_q.size() > 0) ? left_q[0] : -1, rel + DEB + 3);
        key_left_n = 1'b1;
        repeat (10) step();

        // glitches then a real press
        clear_q();
        key_left_n = 1'b0; step(); key_left_n = 1'b1; step();
        key_left_n = 1'b0; step(); key_left_n = 1'b1; step(); step();
        key_left_n = 1'b0; repeat (10) step();
        key_left_n = 1'b1; repeat (15) step();
        chk("glitch_left_cnt", left_q.size(), 1);

        // simultaneous left + rot
        clear_q();
        key_left_n = 1'b0; key_rot_n = 1'b0; repeat (10) step();
        key_left_n = 1'b1; key_rot_n = 1'b1; repeat (12) step();
        chk("lr_left_cnt", left_q.size(), 1);
        chk("lr_rot_cnt", rot_q.size(), 1);
        chk("lr_rot_after_left",
            (left_q.size() > 0 && rot_q.size() > 0) ? rot_q[0] - left_q[0] : -1, 1);

        // gravity periods per level
        score = 5'd0;  meas_grav(40, "grav_lvl0");
        score = 5'd12; meas_grav(28, "grav_lvl3");
        score = 5'd31; meas_grav(12, "grav_lvl7");
        chk("level7", {29'd0, level}, 7);

        // right press lands on a gravity tick
        score = 5'd0; repeat (5) step();
        clear_q();
        wait_tick(t);
        right_q.delete();
        for (int i = 0; i < 100 && cyc < t + 33; i++) step();
        key_right_n = 1'b0; repeat (10) step();
        key_right_n = 1'b1;
        for (int i = 0; i < 100 && cyc < t + 85; i++) step();
        chk("coinc_right", (right_q.size() > 0) ? right_q[0] : -1, t + 40);
        chk("coinc_tick1", (grav_q.size() > 1) ? grav_q[1] : -1, t + 41);
        chk("coinc_tick2", (grav_q.size() > 2) ? grav_q[2] : -1, t + 80);

        // pause for 100 cycles mid-count, key pressed inside the pause
        wait_tick(t);
        clear_q();
        repeat (15) step();
        pause = 1'b1; repeat (20) step();
        key_left_n = 1'b0; repeat (10) step();
        key_left_n = 1'b1; repeat (70) step();
        pause = 1'b0;
        for (int i = 0; i < 100 && cyc < t + 160; i++) step();
        chk("pause_no_left", left_q.size(), 0);
        chk("pause_next_tick", (grav_q.size() > 0) ? grav_q[0] : -1, t + 140);

        // long hold
        clear_q();
        key_left_n = 1'b0; repeat (50) step();
        key_left_n = 1'b1; repeat (15) step();
`ifdef TETRIS_AUTOREPEAT_EN
        chk("hold_left_cnt", left_q.size(), 5);
        for (int k = 1; k < 5; k++)
            chk($sformatf("rpt_off%0d", k),
                (left_q.size() > k) ? left_q[k] - left_q[0] : -1, rep_off[k]);
`else
        chk("hold_left_cnt", left_q.size(), 1);
`endif

        // randomized traffic against the model
        for (int seg = 0; seg < 400; seg++) begin
            key_left_n  = ($urandom_range(0, 3) != 0);
            key_right_n = ($urandom_range(0, 3) != 0);
            key_rot_n   = ($urandom_range(0, 3) != 0);
            pause       = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) score = 5'($urandom_range(0, 31));
            repeat ($urandom_range(1, 12)) step();
        end
        key_left_n = 1'b1; key_right_n = 1'b1; key_rot_n = 1'b1; pause = 1'b0;
        repeat (30) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tetris_input_ctrl.md
TETRIS_INPUT_CTRL -- requirements
Module: tetris_input_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 1000000, meaning consecutive stable cycles (20 ms) needed to accept a raw key change.
REQ-002 SHALL have parameter GRAV_BASE, default 50000000, meaning the gravity period in cycles at level 0.
REQ-003 SHALL have parameter GRAV_STEP, default 5000000, meaning the period reduction per level.
REQ-004 SHALL have parameter REPEAT_DELAY, default 15000000, meaning the hold time before auto-repeat starts.
REQ-005 SHALL have parameter REPEAT_RATE, default 5000000, meaning the auto-repeat interval.
REQ-006 SHALL have ports: CLOCK_50 in 1 system clock; resetn in 1 reset (synchronous, active-low, clock CLOCK_50).
REQ-007 SHALL have ports: key_left_n, key_right_n, key_rot_n in 1 each, raw asynchronous push-buttons, low = pressed.
REQ-008 SHALL have ports: pause in 1 (switch, asynchronous); score in 5, locked-piece count from the game logic.
REQ-009 SHALL have ports: left_final, right_final, rot_final out 1 each, single-cycle move requests to the game logic.
REQ-010 SHALL have ports: tick_gravity out 1, single-cycle gravity request; level out 3, current speed level.

Function
REQ-011 Each key and pause SHALL pass through a 2-flop synchronizer before use; sync latency is 2 cycles.
REQ-012 Each key debouncer SHALL hold a stable state (released after reset) and a counter; counter clears whenever the synced input equals the stable state, else it increments.
REQ-013 The stable state SHALL flip on the cycle the counter reaches DEB_CYCLES-1; the counter then clears.
REQ-014 A released->pressed stable flip SHALL raise a press event for exactly one cycle; pressed->released raises nothing.
REQ-015 At most one of left_final/right_final/rot_final/tick_gravity SHALL be high per cycle; priority left > right > rot > gravity.
REQ-016 A losing event SHALL be held in a per-source pending bit and issued on the first later cycle with no higher-priority event; a second event of the same source while pending is merged (not counted).
REQ-017 level SHALL be registered each cycle as min(score >> 2, 7).
REQ-018 Gravity counter SHALL count 0..P-1 with P = GRAV_BASE - level*GRAV_STEP, raising the gravity event at P-1 and wrapping to 0.
REQ-019 If level rises so that counter >= P-1, the gravity event SHALL fire on the next cycle and the counter wraps to 0.
REQ-020 While synced pause = 1: gravity counter holds, no outputs assert, all pending bits clear, new press events are discarded; debouncers keep running.
REQ-021 Leaving pause SHALL resume the gravity count from its held value.
REQ-022 Output pulses SHALL be registered; press-to-pulse latency is 1 cycle after the debounce flip when unblocked.

Reset
REQ-023 While resetn = 0 at a CLOCK_50 edge: all outputs 0, level 0, all counters 0, stable states released, pending bits 0, repeat FSMs IDLE.
REQ-024 A key held through reset release SHALL produce a press pulse after DEB_CYCLES once synced, since stable resets to released.

Configuration
REQ-025 With TETRIS_AUTOREPEAT_EN defined, left and right each SHALL have an FSM IDLE -> DELAY (on press event) -> REPEAT (after REPEAT_DELAY cycles held), issuing one extra event entering REPEAT and every REPEAT_RATE cycles thereafter; any stable release returns to IDLE.
REQ-026 Without TETRIS_AUTOREPEAT_EN, repeat logic SHALL be absent and each press yields exactly one event; rot never repeats in either build.

Structure
REQ-027 Package tetris_pkg SHALL hold default timing constants, LEVEL_MAX = 7, level width, and the event priority order.
REQ-028 The debouncer SHALL be sub-module btn_debounce (sync + counter + press pulse), instantiated three times.

Verification (DEB_CYCLES=4, GRAV_BASE=40, GRAV_STEP=4, REPEAT_DELAY=20, REPEAT_RATE=8)
REQ-029 key_left_n low held 10 cycles, with 1-cycle glitches of 2 cycles before it -> exactly one left_final pulse, none for the glitches.
REQ-030 Left and rot pressed on the same cycle -> left_final at cycle N, rot_final at N+1, never both high.
REQ-031 score=0, no keys -> tick_gravity every 40 cycles; score=12 (level 3) -> every 28 cycles; score=31 -> level 7, every 12 cycles.
REQ-032 Gravity event coinciding with right_final -> tick_gravity delayed exactly 1 cycle, next tick still on original grid.
REQ-033 pause high for 100 cycles mid-count -> no pulses; after release, next tick after remaining count; key pressed during pause -> no pulse.
REQ-034 With TETRIS_AUTOREPEAT_EN, left held 50 cycles after debounce -> pulses at 0, 20, 28, 36, 44; without it -> single pulse.
